// File: rtl/ad9226_sample_s_axi_regs.sv
// AXI4-Lite register file for the AD9226 sample IP: capture control registers,
// start pulse, and live/sticky status from the sample datapath.
module ad9226_sample_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              ctrl_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     sample_len,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_aux0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_aux1,
    input  logic                              sample_busy,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     sample_cnt
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    logic          aw_held;
    logic [2:0]    aw_idx;
    logic          w_held;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic          bvalid_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] regs [4];
    logic          busy_q;
    logic          done;

    logic          commit;
    logic [DW-1:0] merged;
    logic          busy_fall;
    logic          clr_done;
    logic [2:0]    ar_idx;
    logic [DW-1:0] rd_mux;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = !aw_held;
    assign s00_axi_wready  = !w_held;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = !rvalid_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;

    assign sample_len = regs[1];
    assign ctrl_aux0  = regs[2];
    assign ctrl_aux1  = regs[3];

    assign commit    = aw_held && w_held && (!bvalid_q || s00_axi_bready);
    assign busy_fall = busy_q && !sample_busy;
    assign clr_done  = commit && (aw_idx == 3'd4) && w_strb[0] && w_data[1];
    assign ar_idx    = s00_axi_araddr[4:2];

    always_comb begin
        merged = regs[aw_idx[1:0]];
        for (int unsigned b = 0; b < NB; b++) begin
            if (w_strb[b]) merged[8*b +: 8] = w_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (ar_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_mux = regs[ar_idx[1:0]];
            3'd4: begin
                rd_mux[0] = sample_busy;
                rd_mux[1] = done;
            end
            3'd5:    rd_mux = sample_cnt;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            aw_held    <= 1'b0;
            aw_idx     <= '0;
            w_held     <= 1'b0;
            w_data     <= '0;
            w_strb     <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ctrl_start <= 1'b0;
            busy_q     <= 1'b0;
            done       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            ctrl_start <= 1'b0;
            busy_q     <= sample_busy;

            if (s00_axi_awvalid && !aw_held) begin
                aw_held <= 1'b1;
                aw_idx  <= s00_axi_awaddr[4:2];
            end
            if (s00_axi_wvalid && !w_held) begin
                w_held <= 1'b1;
                w_data <= s00_axi_wdata;
                w_strb <= s00_axi_wstrb;
            end

            // Accept and commit never overlap: accept needs !held, commit needs held.
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                if (!aw_idx[2]) regs[aw_idx[1:0]] <= merged;
                if (aw_idx == 3'd0) ctrl_start <= merged[0];
            end else if (s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (busy_fall)     done <= 1'b1;
            else if (clr_done) done <= 1'b0;

            if (s00_axi_arvalid && !rvalid_q) begin
                rdata_q  <= rd_mux;
                rvalid_q <= 1'b1;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule
